// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: shared definitions for the registered ALU.
//   - OP_* : 4-bit opcode map carried on ctrl
//   - state_e : FSM state encoding of alu_pipe (IDLE, MUL, DONE)
package alu_pipe_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_NOT  = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_NOR  = 4'b0110;
    localparam logic [3:0] OP_SHL  = 4'b0111;
    localparam logic [3:0] OP_SHR  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_ROL  = 4'b1010;
    localparam logic [3:0] OP_ROR  = 4'b1011;
    localparam logic [3:0] OP_EQ   = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_pipe_mul.sv
// alu_pipe_mul: iterative unsigned shift-add multiplier, one partial
// product per cycle, WIDTH cycles per multiply.
//   clk, reset   : clock, synchronous active-high reset
//   start_i      : load a_i/b_i and begin (ignored while busy)
//   a_i, b_i     : unsigned operands
//   busy_o       : a multiply is in flight or its product is being held
//   done_o       : all WIDTH steps finished; product_o is final
//   product_o    : full 2*WIDTH-bit product
// done_o drops on the edge after it rises (the consumer takes the product then).
module alu_pipe_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;

    assign done_o    = busy_q && (cnt_q == CNT_LAST);
    assign busy_o    = busy_q;
    assign product_o = acc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start_i && !busy_q) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            acc_q    <= '0;
            mplier_q <= b_i;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (done_o) begin
            busy_q   <= 1'b0;
        end else if (busy_q) begin
            // Add the shifted multiplicand when the current multiplier LSB is set.
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready input and output handshakes.
// Optional build macro: ALU_PIPE_MUL_EN enables opcode 1101 as an iterative
// unsigned multiply (WIDTH+1 cycles to result); when undefined 1101 yields 0.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake
//   ctrl, x, y          : opcode and operands, sampled on the accepting edge
//   out_valid/out_ready : result handshake
//   out, carry, overflow, zero : registered result and flags
//   state_o             : current FSM state (debug)
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; the producer holds its payload stable while valid is high and not yet
// taken, and the result register holds out/flags stable until taken.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output state_e           state_o
);

    localparam int SW = $clog2(WIDTH);

    // Single-cycle operations; returns {carry, overflow, result}.
    function automatic logic [WIDTH+1:0] alu_op(input logic [3:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH:0]   ae;
        logic [WIDTH:0]   be;
        logic [WIDTH:0]   s;
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
        ae = {a[WIDTH-1], a};
        be = {b[WIDTH-1], b};
        s  = '0;
        r  = '0;
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            OP_ADD: begin
                s = ae + be;
                r = s[WIDTH-1:0];
                c = s[WIDTH];
                v = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                s = ae - be;
                r = s[WIDTH-1:0];
                c = s[WIDTH];
                // Sign of -y is the inverse of sign(y).
                v = (a[WIDTH-1] != b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_NOT: r = ~a;
            OP_XOR: r = a ^ b;
            OP_NOR: r = ~(a | b);
            OP_SHL: r = b << a[SW-1:0];
            OP_SHR: r = b >> a[SW-1:0];
            OP_SRA: r = {a[WIDTH-1], a[WIDTH-1:1]};
            OP_ROL: r = {a[WIDTH-2:0], a[WIDTH-1]};
            OP_ROR: r = {a[0], a[WIDTH-1:1]};
            OP_EQ:  r[0] = (a == b);
            default: r = '0;
        endcase
        return {c, v, r};
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             accept;
    logic             mul_start;
    logic [WIDTH+1:0] res;

`ifdef ALU_PIPE_MUL_EN
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    alu_pipe_mul #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .reset     (reset),
        .start_i   (mul_start),
        .a_i       (x),
        .b_i       (y),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );
`endif

    assign res    = alu_op(ctrl, x, y);
    assign accept = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        mul_start = 1'b0;
        in_ready  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // In DONE a new op may enter only on the edge the result leaves.
                in_ready = (state_q == ST_IDLE) ? 1'b1 : out_ready;
                if (state_q == ST_DONE && out_ready) begin
                    state_d = ST_IDLE;
                end
                if (accept) begin
`ifdef ALU_PIPE_MUL_EN
                    if (ctrl == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = ST_MUL;
                    end else
`endif
                    begin
                        {carry_d, ovf_d, out_d} = res;
                        zero_d  = (res[WIDTH-1:0] == '0);
                        state_d = ST_DONE;
                    end
                end
            end
`ifdef ALU_PIPE_MUL_EN
            ST_MUL: begin
                if (mul_done) begin
                    out_d   = mul_prod[WIDTH-1:0];
                    carry_d = |mul_prod[2*WIDTH-1:WIDTH];
                    ovf_d   = 1'b0;
                    zero_d  = (mul_prod[WIDTH-1:0] == '0);
                    state_d = ST_DONE;
                end else if (!mul_busy) begin
                    // Multiplier lost its operation; recover rather than hang.
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign out_valid = (state_q == ST_DONE);
    assign out       = out_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   ctrl;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         carry;
  logic         overflow;
  logic         zero;
  state_e       dbg_state;

  int errors;
  int checks;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] e_out;
    logic       e_c;
    logic       e_v;
    logic       e_z;
  } vec_t;

  vec_t vecs[$];

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ctrl      (ctrl),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .state_o   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ctrl      = '0;
    x         = '0;
    y         = '0;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic add_vec(input string n, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] eo, input logic ec,
                         input logic ev, input logic ez);
    vec_t v;
    v.name = n; v.op = op; v.a = a; v.b = b;
    v.e_out = eo; v.e_c = ec; v.e_v = ev; v.e_z = ez;
    vecs.push_back(v);
  endtask

  // driver: single accept with out_ready=1, check result, check it drains
  task automatic apply_vec(input vec_t v);
    ctrl      = v.op;
    x         = v.a;
    y         = v.b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({v.name, " in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    check({v.name, " out_valid"}, out_valid, 1);
    check({v.name, " out"}, out, v.e_out);
    check({v.name, " carry"}, carry, v.e_c);
    check({v.name, " overflow"}, overflow, v.e_v);
    check({v.name, " zero"}, zero, v.e_z);
    step();
    check({v.name, " drained"}, out_valid, 0);
  endtask

  task automatic start_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    ctrl     = op;
    x        = a;
    y        = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int cycles;
    errors = 0;
    checks = 0;
    do_reset();

    // reset state
    check("rst out_valid", out_valid, 0);
    check("rst out", out, 0);
    check("rst carry", carry, 0);
    check("rst overflow", overflow, 0);
    check("rst zero", zero, 1);
    check("rst in_ready", in_ready, 1);
    check("rst state", dbg_state, ST_IDLE);

    // vector table
    add_vec("add_7f_01",  4'b0000, 8'h7F, 8'h01, 8'h80, 0, 1, 0);
    add_vec("sub_00_01",  4'b0001, 8'h00, 8'h01, 8'hFF, 1, 0, 0);
    add_vec("eq_same",    4'b1100, 8'h5A, 8'h5A, 8'h01, 0, 0, 0);
    add_vec("eq_diff",    4'b1100, 8'h5A, 8'h5B, 8'h00, 0, 0, 1);
    add_vec("shl_3",      4'b0111, 8'h03, 8'h01, 8'h08, 0, 0, 0);
    add_vec("shl_mask",   4'b0111, 8'h0B, 8'hFF, 8'hF8, 0, 0, 0);
    add_vec("shr_2",      4'b1000, 8'h02, 8'h80, 8'h20, 0, 0, 0);
    add_vec("sra_80",     4'b1001, 8'h80, 8'h00, 8'hC0, 0, 0, 0);
    add_vec("rol_81",     4'b1010, 8'h81, 8'h00, 8'h03, 0, 0, 0);
    add_vec("ror_01",     4'b1011, 8'h01, 8'h00, 8'h80, 0, 0, 0);
    add_vec("add_ff_01",  4'b0000, 8'hFF, 8'h01, 8'h00, 0, 0, 1);
    add_vec("add_80_80",  4'b0000, 8'h80, 8'h80, 8'h00, 1, 1, 1);
    add_vec("sub_80_01",  4'b0001, 8'h80, 8'h01, 8'h7F, 1, 1, 0);
    add_vec("and",        4'b0010, 8'hF0, 8'h3C, 8'h30, 0, 0, 0);
    add_vec("or",         4'b0011, 8'hF0, 8'h0F, 8'hFF, 0, 0, 0);
    add_vec("not",        4'b0100, 8'h55, 8'h00, 8'hAA, 0, 0, 0);
    add_vec("xor",        4'b0101, 8'hFF, 8'h0F, 8'hF0, 0, 0, 0);
    add_vec("nor",        4'b0110, 8'hF0, 8'h0F, 8'h00, 0, 0, 1);
    add_vec("op_1110",    4'b1110, 8'hFF, 8'hFF, 8'h00, 0, 0, 1);
    add_vec("op_1111",    4'b1111, 8'h7F, 8'h01, 8'h00, 0, 0, 1);
`ifndef ALU_PIPE_MUL_EN
    add_vec("mul_off",    4'b1101, 8'h10, 8'h10, 8'h00, 0, 0, 1);
`endif
    foreach (vecs[i]) apply_vec(vecs[i]);

    // back-pressure: result held while out_ready=0, other inputs ignored
    out_ready = 1'b0;
    start_op(4'b0000, 8'h01, 8'h02);
    in_valid = 1'b1;
    ctrl = 4'b0001; x = 8'hAA; y = 8'h11;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp in_ready", in_ready, 0);
      step();
      check("bp out_valid", out_valid, 1);
      check("bp out", out, 8'h03);
      check("bp flags", {carry, overflow, zero}, 3'b000);
      x = x + 8'h01;
    end
    // release with a simultaneous accept
    ctrl = 4'b0101; x = 8'h0F; y = 8'hF0;
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("bp next out_valid", out_valid, 1);
    check("bp next out", out, 8'hFF);
    step();
    check("bp next drained", out_valid, 0);

    // reset with a result pending discards it
    out_ready = 1'b0;
    start_op(4'b0000, 8'h05, 8'h05);
    check("pend out_valid", out_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("pend rst out_valid", out_valid, 0);
    check("pend rst out", out, 0);
    check("pend rst zero", zero, 1);

`ifdef ALU_PIPE_MUL_EN
    // multiply 10*10: exactly W+1 cycles, in_ready low throughout
    out_ready = 1'b1;
    start_op(4'b1101, 8'h10, 8'h10);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      check("mul in_ready", in_ready, 0);
      step();
      cycles++;
    end
    check("mul latency", cycles, 9);
    check("mul out", out, 8'h00);
    check("mul carry", carry, 1);
    check("mul zero", zero, 1);
    check("mul overflow", overflow, 0);
    step();

    start_op(4'b1101, 8'h0F, 8'h0F);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      step();
      cycles++;
    end
    check("mul2 latency", cycles, 9);
    check("mul2 out", out, 8'hE1);
    check("mul2 carry", carry, 0);
    step();

    // reset 3 cycles into a multiply
    start_op(4'b1101, 8'h0F, 8'h0F);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mulrst out_valid", out_valid, 0);
    check("mulrst out", out, 0);
    check("mulrst in_ready", in_ready, 1);
    cycles = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (out_valid) cycles++;
    end
    check("mulrst no stale", cycles, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
